// File: rtl/ahb_mem_bridge.sv
// AHB-Lite slave to valid/ready memory bridge with a posted write buffer,
// HSIZE-derived byte strobes and a two-cycle ERROR response for bad accesses.
module ahb_mem_bridge #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           WBUF_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = '0,
    parameter logic [ADDR_WIDTH-1:0] MEM_SIZE   = ADDR_WIDTH'(32'h1000)
) (
    input  logic                              i_clk_ahb,
    input  logic                              i_rst_ahb,
    input  logic                              i_hselx,
    input  logic                              i_hready,
    input  logic [1:0]                        i_htrans,
    input  logic [2:0]                        i_hsize,
    input  logic                              i_hwrite,
    input  logic [ADDR_WIDTH-1:0]             i_haddr,
    input  logic [DATA_WIDTH-1:0]             i_hwdata,
    output logic                              o_hreadyout,
    output logic                              o_hresp,
    output logic [DATA_WIDTH-1:0]             o_hrdata,
    output logic                              o_valid,
    output logic                              o_rd0_wr1,
    output logic [ADDR_WIDTH-1:0]             o_addr,
    output logic [DATA_WIDTH-1:0]             o_wr_data,
    output logic [DATA_WIDTH/8-1:0]           o_wr_strb,
    input  logic                              i_ready,
    input  logic                              i_rd_valid,
    input  logic [DATA_WIDTH-1:0]             i_rd_data,
    output logic [$clog2(WBUF_DEPTH+1)-1:0]   o_wbuf_level
);

    localparam int unsigned STRB_W    = DATA_WIDTH / 8;
    localparam int unsigned LANE_BITS = $clog2(STRB_W);
    localparam int unsigned PTR_W     = $clog2(WBUF_DEPTH);
    localparam int unsigned LVL_W     = $clog2(WBUF_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_RESP,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                  state_q, state_d, addr_state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [2:0]              size_q;
    logic [DATA_WIDTH-1:0]   hrdata_q;

    logic [ADDR_WIDTH-1:0]   buf_addr_q [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0]   buf_data_q [WBUF_DEPTH];
    logic [STRB_W-1:0]       buf_strb_q [WBUF_DEPTH];
    logic [PTR_W-1:0]        wptr_q, rptr_q;
    logic [LVL_W-1:0]        level_q, level_d;

    logic                    accept, in_window, bad_size, misaligned, addr_err;
    logic [LANE_BITS-1:0]    align_mask;
    logic                    hready_c, hresp_c;
    logic                    buf_full, buf_empty, push, pop, rd_req;
    logic [7:0]              nbytes;
    logic [STRB_W-1:0]       strb_base, strb_c;

    // Address-phase decode and legality check
    assign accept     = i_hselx & i_hready & i_htrans[1];
    assign in_window  = ({1'b0, i_haddr} >= {1'b0, MEM_BASE}) &&
                        ({1'b0, i_haddr} <  ({1'b0, MEM_BASE} + {1'b0, MEM_SIZE}));
    assign bad_size   = i_hsize > 3'(LANE_BITS);
    assign align_mask = ~({LANE_BITS{1'b1}} << i_hsize);
    assign misaligned = |(i_haddr[LANE_BITS-1:0] & align_mask);
    assign addr_err   = !in_window || bad_size || misaligned;
    assign addr_state = addr_err ? S_ERR1 : (i_hwrite ? S_WRITE : S_RD_REQ);

    assign nbytes     = 8'd1 << size_q;
    assign strb_base  = ~({STRB_W{1'b1}} << nbytes);
    assign strb_c     = strb_base << addr_q[LANE_BITS-1:0];

    assign buf_full   = (level_q == LVL_W'(WBUF_DEPTH));
    assign buf_empty  = (level_q == '0);
    // Full is judged on the registered level, so a same-cycle pop never frees a slot for a push
    assign push       = (state_q == S_WRITE) && !buf_full;
    assign pop        = !buf_empty && i_ready;
    assign rd_req     = (state_q == S_RD_REQ) && buf_empty;

    always_comb begin
        state_d  = state_q;
        hready_c = 1'b1;
        hresp_c  = 1'b0;
        case (state_q)
            S_IDLE:    ;
            S_WRITE:   hready_c = !buf_full;
            S_RD_REQ: begin
                hready_c = 1'b0;
                if (rd_req && i_ready) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                hready_c = 1'b0;
                if (i_rd_valid) state_d = S_RD_RESP;
            end
            S_RD_RESP: ;
            S_ERR1: begin
                hready_c = 1'b0;
                hresp_c  = 1'b1;
                state_d  = S_ERR2;
            end
            S_ERR2:    hresp_c = 1'b1;
            default:   state_d = S_IDLE;
        endcase
        if (hready_c) state_d = accept ? addr_state : S_IDLE;
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop)      level_d = level_q + LVL_W'(1);
        else if (pop && !push) level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge i_clk_ahb) begin
        if (i_rst_ahb) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            hrdata_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            if (accept && hready_c) begin
                addr_q <= i_haddr;
                size_q <= i_hsize;
            end
            if (state_q == S_RD_WAIT && i_rd_valid) hrdata_q <= i_rd_data;
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge i_clk_ahb) begin
        if (push) begin
            buf_addr_q[wptr_q] <= addr_q;
            buf_data_q[wptr_q] <= i_hwdata;
            buf_strb_q[wptr_q] <= strb_c;
        end
    end

    assign o_hreadyout  = hready_c;
    assign o_hresp      = hresp_c;
    assign o_hrdata     = hrdata_q;
    assign o_wbuf_level = level_q;
    assign o_valid      = !buf_empty || rd_req;
    assign o_rd0_wr1    = !buf_empty;
    assign o_addr       = !buf_empty ? buf_addr_q[rptr_q] : (rd_req ? addr_q : '0);
    assign o_wr_data    = !buf_empty ? buf_data_q[rptr_q] : '0;
    assign o_wr_strb    = !buf_empty ? buf_strb_q[rptr_q] : (rd_req ? '1 : '0);

endmodule

// File: tb/tb_ahb_mem_bridge.sv
// Scoreboard bench for ahb_mem_bridge: stimulus queues expected AHB responses and
// memory requests; independent monitors pop and compare as the DUT presents them.
module tb_ahb_mem_bridge;

    typedef struct {
        logic [1:0]  trans;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        bit          resp;
        bit          is_rd;
        logic [31:0] rdata;
        int          waits;
    } ahb_exp_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } mem_exp_t;

    logic        clk, rst;
    logic        hsel, hready, hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr, hwdata;
    logic        hreadyout, hresp;
    logic [31:0] hrdata;
    logic        mvalid, rd0wr1, mready, rd_valid;
    logic [31:0] maddr, mwdata, rd_data;
    logic [3:0]  mstrb;
    logic [2:0]  level;

    int errors = 0;
    int checks = 0;

    xfer_t       seq[$];
    ahb_exp_t    ahb_exp[$];
    mem_exp_t    mem_exp[$];
    logic [31:0] mem_model [logic [31:0]];

    assign hready = hreadyout;

    ahb_mem_bridge #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .WBUF_DEPTH (4),
        .MEM_BASE   (32'h0),
        .MEM_SIZE   (32'h1000)
    ) dut (
        .i_clk_ahb    (clk),
        .i_rst_ahb    (rst),
        .i_hselx      (hsel),
        .i_hready     (hready),
        .i_htrans     (htrans),
        .i_hsize      (hsize),
        .i_hwrite     (hwrite),
        .i_haddr      (haddr),
        .i_hwdata     (hwdata),
        .o_hreadyout  (hreadyout),
        .o_hresp      (hresp),
        .o_hrdata     (hrdata),
        .o_valid      (mvalid),
        .o_rd0_wr1    (rd0wr1),
        .o_addr       (maddr),
        .o_wr_data    (mwdata),
        .o_wr_strb    (mstrb),
        .i_ready      (mready),
        .i_rd_valid   (rd_valid),
        .i_rd_data    (rd_data),
        .o_wbuf_level (level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return {16'hD00D, a[15:0]};
    endfunction

    task automatic add_xfer(input logic [1:0] tr, input bit wr, input logic [31:0] a,
                            input logic [2:0] sz, input logic [31:0] d, input bit err,
                            input logic [31:0] rexp, input int w);
        xfer_t    x;
        ahb_exp_t e;
        x.trans = tr; x.wr = wr; x.addr = a; x.size = sz; x.wdata = d;
        seq.push_back(x);
        if (tr[1]) begin
            e.resp = err; e.is_rd = !wr && !err; e.rdata = rexp; e.waits = w;
            ahb_exp.push_back(e);
        end
    endtask

    task automatic add_mem(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
        mem_exp_t m;
        m.wr = wr; m.addr = a; m.data = d; m.strb = s;
        mem_exp.push_back(m);
    endtask

    // AHB master: drives address phases pipelined with the previous data phase
    task automatic run_seq();
        int          ai;
        int          guard;
        bit          dpv, dpwr, rdy;
        logic [31:0] dpd;
        ai = 0; guard = 0; dpv = 0; dpwr = 0; dpd = '0;
        while ((ai < seq.size() || dpv) && guard < 200) begin
            if (ai < seq.size()) begin
                hsel = 1'b1; htrans = seq[ai].trans; hwrite = seq[ai].wr;
                haddr = seq[ai].addr; hsize = seq[ai].size;
            end else begin
                hsel = 1'b0; htrans = 2'b00;
            end
            hwdata = (dpv && dpwr) ? dpd : '0;
            @(negedge clk);
            rdy = hreadyout;
            @(posedge clk);
            #1;
            guard++;
            if (rdy) begin
                dpv = 1'b0;
                if (ai < seq.size()) begin
                    dpv  = seq[ai].trans[1];
                    dpwr = seq[ai].wr;
                    dpd  = seq[ai].wdata;
                    ai++;
                end
            end
        end
        if (guard >= 200) begin
            checks++; errors++;
            $display("FAIL master_timeout: got %0d transfers issued, expected %0d", ai, seq.size());
        end
        hsel = 1'b0; htrans = 2'b00; hwdata = '0;
        seq.delete();
    endtask

    // AHB response monitor
    initial begin : ahb_mon
        bit       dp;
        int       waits;
        ahb_exp_t e;
        dp = 0; waits = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                dp = 0; waits = 0;
            end else begin
                if (dp) begin
                    if (!hreadyout) waits++;
                    else begin
                        if (ahb_exp.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL ahb_unexpected: got completion hresp=%0b, expected none", hresp);
                        end else begin
                            e = ahb_exp.pop_front();
                            chk("hresp", 64'(hresp), 64'(e.resp));
                            if (e.waits >= 0) chk("wait_states", 64'(waits), 64'(e.waits));
                            if (e.is_rd) chk("hrdata", 64'(hrdata), 64'(e.rdata));
                        end
                        dp = 0;
                    end
                end
                if (hreadyout && hsel && htrans[1]) begin
                    dp = 1; waits = 0;
                end
            end
        end
    end

    // Memory port monitor and responder
    initial begin : mem_mon
        bit          rd_hs;
        logic [31:0] rd_addr, a, w;
        mem_exp_t    m;
        rd_valid = 1'b0; rd_data = '0;
        forever begin
            @(negedge clk);
            rd_hs = 0; rd_addr = '0;
            if (!rst && mvalid && mready) begin
                if (mem_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_unexpected: got rw=%0b addr=%h, expected none", rd0wr1, maddr);
                end else begin
                    m = mem_exp.pop_front();
                    chk("mem_rw", 64'(rd0wr1), 64'(m.wr));
                    chk("mem_addr", 64'(maddr), 64'(m.addr));
                    chk("mem_strb", 64'(mstrb), 64'(m.strb));
                    if (m.wr) chk("mem_wdata", 64'(mwdata), 64'(m.data));
                end
                a = {maddr[31:2], 2'b00};
                if (rd0wr1) begin
                    w = mem_model.exists(a) ? mem_model[a] : mem_default(a);
                    for (int b = 0; b < 4; b++) if (mstrb[b]) w[8*b +: 8] = mwdata[8*b +: 8];
                    mem_model[a] = w;
                end else begin
                    chk("read_waits_empty_buf", 64'(level), 64'(0));
                    rd_hs = 1; rd_addr = a;
                end
            end
            @(posedge clk);
            #1;
            rd_valid = rd_hs;
            if (rd_hs) rd_data = mem_model.exists(rd_addr) ? mem_model[rd_addr] : mem_default(rd_addr);
        end
    end

    initial begin : stim
        int maxl;
        bit seen;
        rst = 1'b1; hsel = 1'b0; htrans = 2'b00; hsize = 3'd0; hwrite = 1'b0;
        haddr = '0; hwdata = '0; mready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hreadyout", 64'(hreadyout), 64'(1));
        chk("rst_hresp", 64'(hresp), 64'(0));
        chk("rst_hrdata", 64'(hrdata), 64'(0));
        chk("rst_valid", 64'(mvalid), 64'(0));
        chk("rst_rd0_wr1", 64'(rd0wr1), 64'(0));
        chk("rst_addr", 64'(maddr), 64'(0));
        chk("rst_wr_data", 64'(mwdata), 64'(0));
        chk("rst_wr_strb", 64'(mstrb), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0; mready = 1'b1;

        // Word burst with a BUSY beat, memory always ready
        add_xfer(2'b10, 1, 32'h10, 3'd2, 32'hA0A0_0010, 0, 0, 0);
        add_xfer(2'b11, 1, 32'h14, 3'd2, 32'hA0A0_0014, 0, 0, 0);
        add_xfer(2'b01, 1, 32'h18, 3'd2, 32'h0, 0, 0, 0);
        add_xfer(2'b11, 1, 32'h18, 3'd2, 32'hA0A0_0018, 0, 0, 0);
        add_xfer(2'b11, 1, 32'h1C, 3'd2, 32'hA0A0_001C, 0, 0, 0);
        add_mem(1, 32'h10, 32'hA0A0_0010, 4'hF);
        add_mem(1, 32'h14, 32'hA0A0_0014, 4'hF);
        add_mem(1, 32'h18, 32'hA0A0_0018, 4'hF);
        add_mem(1, 32'h1C, 32'hA0A0_001C, 4'hF);
        maxl = 0;
        fork
            run_seq();
            repeat (12) begin
                @(negedge clk);
                if (int'(level) > maxl) maxl = int'(level);
            end
        join
        chk("burst_level_peak", 64'(maxl), 64'(1));
        repeat (4) @(posedge clk);
        #1;

        // Six writes against a stalled memory fill the buffer
        mready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            add_xfer(2'b10, 1, 32'h40 + 32'(4 * i), 3'd2, 32'h6000_0000 + 32'(i), 0, 0, (i == 4) ? -1 : 0);
            add_mem(1, 32'h40 + 32'(4 * i), 32'h6000_0000 + 32'(i), 4'hF);
        end
        fork
            run_seq();
            begin
                seen = 0;
                for (int k = 0; k < 40 && !seen; k++) begin
                    @(negedge clk);
                    if (!hreadyout) seen = 1;
                end
                chk("full_stall_seen", 64'(seen), 64'(1));
                chk("full_level", 64'(level), 64'(4));
                repeat (2) @(posedge clk);
                #1 mready = 1'b1;
                @(negedge clk);
                chk("stall_before_pop", 64'(hreadyout), 64'(0));
                @(negedge clk);
                chk("stall_ends_after_pop", 64'(hreadyout), 64'(1));
            end
        join
        repeat (8) @(posedge clk);
        #1;

        // Byte write strobe, then misaligned halfword error
        add_xfer(2'b10, 1, 32'h13, 3'd0, 32'hAB00_0000, 0, 0, 0);
        add_mem(1, 32'h13, 32'hAB00_0000, 4'b1000);
        add_xfer(2'b10, 1, 32'h11, 3'd1, 32'h1234_5678, 1, 0, 1);
        run_seq();
        repeat (6) @(posedge clk);
        #1;

        // Read-after-write ordering with a delayed memory
        mready = 1'b0;
        add_xfer(2'b10, 1, 32'h20, 3'd2, 32'hCAFE_F00D, 0, 0, 0);
        add_xfer(2'b10, 0, 32'h20, 3'd2, 32'h0, 0, 32'hCAFE_F00D, -1);
        add_mem(1, 32'h20, 32'hCAFE_F00D, 4'hF);
        add_mem(0, 32'h20, 32'h0, 4'hF);
        fork
            run_seq();
            begin
                repeat (3) @(posedge clk);
                #1 mready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Window end errors; following read at the base takes two wait states
        add_xfer(2'b10, 0, 32'h1000, 3'd2, 32'h0, 1, 0, 1);
        add_xfer(2'b10, 0, 32'h0, 3'd2, 32'h0, 0, 32'hD00D_0000, 2);
        add_mem(0, 32'h0, 32'h0, 4'hF);
        run_seq();
        repeat (4) @(posedge clk);
        #1;

        // Reset with posted writes pending drops them
        mready = 1'b0;
        add_xfer(2'b10, 1, 32'h80, 3'd2, 32'h8080_8080, 0, 0, 0);
        add_xfer(2'b10, 1, 32'h84, 3'd2, 32'h8484_8484, 0, 0, 0);
        run_seq();
        @(negedge clk);
        chk("pending_level", 64'(level), 64'(2));
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("flush_level", 64'(level), 64'(0));
        chk("flush_valid", 64'(mvalid), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0; mready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        chk("ahb_exp_drained", 64'(ahb_exp.size()), 64'(0));
        chk("mem_exp_drained", 64'(mem_exp.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
